// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/slt/xor, iterative shift-add multiply
// and restoring divide behind a start/busy/done handshake. Divider enabled by ALU_DIV_EN.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       sel_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] out_hi_o,
    output logic             zero_o,
    output logic             slt_check_o,
    output logic             dz_o
);

    // state | meaning
    // IDLE  | waiting for start; results held
    // RUN   | one mul/div iteration per cycle
    // DONE  | done pulse for one cycle, start ignored
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               slt_pend_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   out_hi_q;
    logic               zero_q;
    logic               slt_q;
    logic               dz_q;
`ifdef ALU_DIV_EN
    logic               is_div_q;
`endif

    logic               slt_in;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   iter_hi_d;
    logic [WIDTH-1:0]   iter_lo_d;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
`endif

    assign slt_in = $signed(in1_i) < $signed(in2_i);

    always_comb begin
        alu_res = '0;
        case (sel_i)
            3'b000:  alu_res = in1_i + in2_i;
            3'b001:  alu_res = in1_i - in2_i;
            3'b010:  alu_res = in1_i & in2_i;
            3'b011:  alu_res = in1_i | in2_i;
            3'b100:  alu_res = {WIDTH{slt_in}};
            3'b101:  alu_res = in1_i ^ in2_i;
            default: alu_res = '0;
        endcase
    end

    // Multiply: {hi,lo} shifts right, multiplicand added into hi when lo[0] is set.
    // Divide: {rem,quo} shifts left, divisor subtracted when it fits (no borrow).
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        iter_hi_d = mul_sum[WIDTH:1];
        iter_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, a_q};
        div_ge    = ~div_diff[WIDTH];
        if (is_div_q) begin
            iter_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            iter_lo_d = {lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            slt_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= '0;
            out_hi_q   <= '0;
            zero_q     <= 1'b0;
            slt_q      <= 1'b0;
            dz_q       <= 1'b0;
`ifdef ALU_DIV_EN
            is_div_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        slt_pend_q <= slt_in;
                        if (sel_i == 3'b110) begin
                            a_q     <= in1_i;
                            lo_q    <= in2_i;
                            hi_q    <= '0;
                            cnt_q   <= CNT_W'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
`ifdef ALU_DIV_EN
                            is_div_q <= 1'b0;
                        end else if (sel_i == 3'b111 && in2_i != '0) begin
                            a_q      <= in2_i;
                            lo_q     <= in1_i;
                            hi_q     <= '0;
                            cnt_q    <= CNT_W'(WIDTH);
                            busy_q   <= 1'b1;
                            is_div_q <= 1'b1;
                            state_q  <= RUN;
                        end else if (sel_i == 3'b111) begin
                            out_q    <= '1;
                            out_hi_q <= in1_i;
                            zero_q   <= 1'b0;
                            slt_q    <= slt_in;
                            dz_q     <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
`endif
                        end else begin
                            out_q    <= alu_res;
                            out_hi_q <= '0;
                            zero_q   <= (alu_res == '0);
                            slt_q    <= slt_in;
                            dz_q     <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                RUN: begin
                    hi_q  <= iter_hi_d;
                    lo_q  <= iter_lo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_q    <= iter_lo_d;
                        out_hi_q <= iter_hi_d;
                        zero_q   <= (iter_lo_d == '0);
                        slt_q    <= slt_pend_q;
                        dz_q     <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign out_o       = out_q;
    assign out_hi_o    = out_hi_q;
    assign zero_o      = zero_q;
    assign slt_check_o = slt_q;
    assign dz_o        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: arithmetic reference model checked every cycle, directed literal
// cases, and randomized operations with ignored start pulses during busy.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [2:0]   sel_i = '0;
    logic [W-1:0] in1_i = '0;
    logic [W-1:0] in2_i = '0;
    logic         busy_o, done_o, zero_o, slt_check_o, dz_o;
    logic [W-1:0] out_o, out_hi_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    alu_mc #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sel_i(sel_i),
        .in1_i(in1_i), .in2_i(in2_i), .busy_o(busy_o), .done_o(done_o),
        .out_o(out_o), .out_hi_o(out_hi_o), .zero_o(zero_o),
        .slt_check_o(slt_check_o), .dz_o(dz_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what an accepted op must produce, from plain arithmetic.
    function automatic void compute(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] lo, output logic [W-1:0] hi,
                                    output logic dzf, output bit multi);
        logic [2*W-1:0] prod;
        lo = '0; hi = '0; dzf = 1'b0; multi = 1'b0;
        case (s)
            3'd0: lo = a + b;
            3'd1: lo = a - b;
            3'd2: lo = a & b;
            3'd3: lo = a | b;
            3'd4: lo = ($signed(a) < $signed(b)) ? '1 : '0;
            3'd5: lo = a ^ b;
            3'd6: begin
                prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                lo    = prod[W-1:0];
                hi    = prod[2*W-1:W];
                multi = 1'b1;
            end
`ifdef ALU_DIV_EN
            3'd7: begin
                if (b == '0) begin
                    lo = '1; hi = a; dzf = 1'b1;
                end else begin
                    lo = a / b; hi = a % b; multi = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    endfunction

    logic         m_busy = 0, m_done = 0, m_zero = 0, m_slt = 0, m_dz = 0;
    logic [W-1:0] m_out = '0, m_hi = '0;
    logic         p_zero = 0, p_slt = 0, p_dz = 0;
    logic [W-1:0] p_out = '0, p_hi = '0;
    int           m_rem = 0;

    always begin : compare
        bit multi;
        @(posedge clk_i);
        if (rst_i) begin
            m_busy = 0; m_done = 0; m_zero = 0; m_slt = 0; m_dz = 0;
            m_out = '0; m_hi = '0; m_rem = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_out = p_out; m_hi = p_hi; m_zero = p_zero; m_slt = p_slt; m_dz = p_dz;
                m_busy = 0; m_done = 1;
            end
        end else if (start_i) begin
            compute(sel_i, in1_i, in2_i, p_out, p_hi, p_dz, multi);
            p_zero = (p_out == '0);
            p_slt  = $signed(in1_i) < $signed(in2_i);
            if (multi) begin
                m_rem = W; m_busy = 1;
            end else begin
                m_out = p_out; m_hi = p_hi; m_zero = p_zero; m_slt = p_slt; m_dz = p_dz;
                m_done = 1;
            end
        end
        @(negedge clk_i);
        if (!rst_i) begin
            chk("busy", busy_o, m_busy);
            chk("done", done_o, m_done);
            chk("out", out_o, m_out);
            chk("out_hi", out_hi_o, m_hi);
            chk("zero", zero_o, m_zero);
            chk("slt_check", slt_check_o, m_slt);
            chk("dz", dz_o, m_dz);
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while ((busy_o || done_o) && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        chk("idle_wait_in_bound", guard < 100, 1);
    endtask

    task automatic run_op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit junk, output int lat);
        @(negedge clk_i);
        wait_idle();
        start_i = 1'b1; sel_i = s; in1_i = a; in2_i = b;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 100) begin
            if (junk) begin
                start_i = 1'($urandom_range(0, 1));
                sel_i   = 3'($urandom);
                in1_i   = W'($urandom);
                in2_i   = W'($urandom);
            end
            @(negedge clk_i);
            lat++;
        end
        start_i = 1'b0;
        chk("done_in_bound", lat < 100, 1);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return {1'b1, {(W-1){1'b0}}};
            4: return {1'b0, {(W-1){1'b1}}};
            5: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin : driver
        int lat;
        bit seen;
        #1 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_out", out_o, 0);
        chk("rst_out_hi", out_hi_o, 0);
        chk("rst_zero", zero_o, 0);
        chk("rst_slt", slt_check_o, 0);
        chk("rst_dz", dz_o, 0);
        rst_i = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 0, lat);
        chk("add_wrap_out", out_o, 0);
        chk("add_wrap_zero", zero_o, 1);
        chk("add_wrap_lat", lat, 1);
        run_op(3'd1, 32'd5, 32'd7, 0, lat);
        chk("sub_out", out_o, 32'hFFFF_FFFE);
        run_op(3'd4, 32'h8000_0000, 32'd1, 0, lat);
        chk("slt_neg_out", out_o, 32'hFFFF_FFFF);
        chk("slt_neg_flag", slt_check_o, 1);
        run_op(3'd4, 32'd3, 32'hFFFF_FFFF, 0, lat);
        chk("slt_pos_out", out_o, 0);
        chk("slt_pos_flag", slt_check_o, 0);
        run_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat);
        chk("mul_hi", out_hi_o, 32'hFFFF_FFFE);
        chk("mul_lo", out_o, 1);
        chk("mul_lat", lat, 33);
        run_op(3'd7, 32'd100, 32'd7, 0, lat);
`ifdef ALU_DIV_EN
        chk("div_quo", out_o, 14);
        chk("div_rem", out_hi_o, 2);
        chk("div_dz", dz_o, 0);
        chk("div_lat", lat, 33);
`else
        chk("nodiv_out", out_o, 0);
        chk("nodiv_out_hi", out_hi_o, 0);
        chk("nodiv_zero", zero_o, 1);
        chk("nodiv_lat", lat, 1);
`endif
        run_op(3'd7, 32'd9, 32'd0, 0, lat);
`ifdef ALU_DIV_EN
        chk("dz_out", out_o, 32'hFFFF_FFFF);
        chk("dz_out_hi", out_hi_o, 9);
        chk("dz_flag", dz_o, 1);
`else
        chk("nodiv0_out", out_o, 0);
        chk("nodiv0_zero", zero_o, 1);
        chk("nodiv0_dz", dz_o, 0);
`endif
        chk("dz_lat", lat, 1);
        run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, lat);
        chk("and_out", out_o, 32'h00F0_1234);
        chk("and_out_hi", out_hi_o, 0);
        run_op(3'd6, 32'd3, 32'd5, 0, lat);
        chk("mul_small_lo", out_o, 15);

        // Abort a multiply in its tenth RUN cycle.
        @(negedge clk_i);
        wait_idle();
        start_i = 1'b1; sel_i = 3'd6; in1_i = 32'd7; in2_i = 32'd9;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        chk("pre_abort_busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_out", out_o, 0);
        chk("abort_done", done_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        run_op(3'd0, 32'd1, 32'd1, 0, lat);
        chk("post_abort_add", out_o, 2);
        chk("post_abort_lat", lat, 1);

        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom), rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), lat);
        end
        repeat (3) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath execute stage. It performs single-cycle add, sub, and, or, slt and xor, plus iterative unsigned shift-add multiply and restoring divide. A start/busy/done handshake wraps all operations, and results are registered and held until the next accepted operation.

## Interface
- WIDTH, 32, operand/result width (≥ 4)
- CNT_W, $clog2(WIDTH+1), iteration counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- sel  in  3  op: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 mul, 111 div
- in1  in  WIDTH  operand A, sampled on accept
- in2  in  WIDTH  operand B, sampled on accept
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse, results valid
- out  out  WIDTH  result / product low / quotient
- out_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops
- zero  out  1  out == 0, registered with out
- slt_check  out  1  signed in1 < in2, registered with out
- dz  out  1  divide-by-zero flag for last div

## Operation
- Reset: state IDLE; busy, done, out, out_hi, zero, slt_check, dz all 0; counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE + start:
  - Latch sel/in1/in2.
  - Single-cycle ops (000–101): result registered the same edge, go DONE.
  - mul/div: load operands, counter = WIDTH, go RUN.
- RUN: one iteration per cycle, counter decrements; at counter==1 the final iteration writes results, go DONE.
- DONE: done=1, busy=0 for exactly one cycle → IDLE. Results hold until the next accept.
- start while busy=1 or in DONE: ignored, no queueing.
- slt (signed, two's complement):
  - out = all ones if true, else 0.
  - Mixed signs decided by the MSBs.
  - slt_check is updated for every op from the latched operands.
- add/sub: modulo 2^WIDTH, carry discarded.
- mul: unsigned; {out_hi,out} = full 2·WIDTH product.
- div: unsigned restoring; out = quotient, out_hi = remainder.
  - in2==0: no RUN; go DONE directly with out = all ones, out_hi = in1, dz=1.
  - dz is cleared on any other accepted op.
- zero always reflects the registered out, including mul low half and quotient.
- Reset mid-RUN aborts the operation; no done pulse; outputs return to reset values.

## Timing
- Accept at edge E0 (start=1, busy=0).
- Single-cycle ops and div-by-zero: done high in cycle E0+1; busy never asserts.
- mul / div: busy high E0+1 … E0+WIDTH; done at E0+WIDTH+1 (33 cycles for WIDTH=32).
- Back-to-back: earliest next accept is the cycle after done (start sampled in IDLE).
- Outputs are all registered; no combinational path from inputs to outputs.

## Configuration
- ALU_DIV_EN defined: divider datapath and sel=111 behave as above.
- ALU_DIV_EN undefined:
  - Divider logic is not compiled.
  - sel=111 completes as a single-cycle op with out=0, out_hi=0, zero=1, dz=0.
  - mul is unaffected.

## Test plan
- Reset mid-mul (reset asserted during RUN, cycle 10) → busy=0, out=0, no done pulse; next add 1+1 → out=2, done at E0+1.
- WIDTH=32: add 0xFFFFFFFF+1 → out=0, zero=1, done at E0+1; sub 5−7 → out=0xFFFFFFFE.
- slt: in1=0x80000000, in2=1 → out=0xFFFFFFFF, slt_check=1; in1=3, in2=0xFFFFFFFF → out=0, slt_check=0.
- mul 0xFFFFFFFF×0xFFFFFFFF → out_hi=0xFFFFFFFE, out=1, done exactly 33 cycles after accept; start pulses during busy are ignored.
- div 100÷7 → out=14, out_hi=2, dz=0 at E0+33; div 9÷0 → out=0xFFFFFFFF, out_hi=9, dz=1 at E0+1.
- Build without ALU_DIV_EN: sel=111 → done at E0+1, out=0, zero=1.
